// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the fetch-side control blocks.
//   - default address width and the reset / exception byte vectors
//   - PC-unit state encoding (BOOT / RUN / PEND)
//   - redirect source encoding and the fixed-priority picker
package cpu_pkg;

  localparam int          ADDR_W_DEF    = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0180;
  localparam int          RAS_DEPTH_DEF = 4;

  // PC-unit control state. BOOT lasts one cycle after reset with no fetch
  // request; PEND means a redirect is latched waiting for the next advance.
  typedef logic [1:0] pc_state_t;
  localparam pc_state_t ST_BOOT = 2'd0;
  localparam pc_state_t ST_RUN  = 2'd1;
  localparam pc_state_t ST_PEND = 2'd2;

  // Redirect sources, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_EXC  = 3'd1,
    SRC_RET  = 3'd2,
    SRC_JMP  = 3'd3,
    SRC_BR   = 3'd4
  } redir_src_t;

  // Same-cycle arbitration: Exc > Ret > Jmp > Br. The caller must already
  // have masked Ret when the return stack is empty.
  function automatic redir_src_t redir_pick(input logic exc, input logic ret,
                                            input logic jmp, input logic br);
    if (exc)      return SRC_EXC;
    else if (ret) return SRC_RET;
    else if (jmp) return SRC_JMP;
    else if (br)  return SRC_BR;
    else          return SRC_NONE;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   clk, rst   : clock, async active-high reset (clears entries and count)
//   push       : write push_data at the free slot; when full the oldest entry
//                is overwritten and the count stays saturated at DEPTH
//   pop        : drop the top entry (ignored when already empty)
//   push_data  : return address to store
//   top        : current top entry (meaningless while empty)
//   empty      : registered, high when no entries are held
// DEPTH must be a power of two in 2..16 so the pointer wraps naturally.
module pc_ras
  import cpu_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH_DEF,
  parameter int W     = ADDR_W_DEF - 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;   // next free slot; top lives at ptr_q-1
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty_q, empty_d;
  logic [PTR_W-1:0] top_idx;

  assign top_idx = ptr_q - PTR_W'(1);
  assign top     = mem_q[top_idx];
  assign empty   = empty_q;

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      // Pointer wrap makes a push on a full stack land on the oldest entry.
      mem_d[ptr_q] = push_data;
      ptr_d        = ptr_q + PTR_W'(1);
      if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && (cnt_q != '0)) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CNT_W'(1);
    end
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
    end else begin
      mem_q   <= mem_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: word-addressed fetch program counter with redirect arbitration.
//   Clk, Reset          : clock, async active-high reset
//   Stall               : re-issue the same PC next cycle
//   FetchReady          : instruction memory accepts the request
//   FetchValid, PC      : fetch request and its word address
//   BrTaken/BrTarget    : branch redirect
//   JmpValid/JmpTarget  : jump redirect; Call additionally pushes PC+1
//   Ret                 : return to the RAS top (ignored when RAS empty)
//   Exc                 : redirect to EXC_VEC, Epc captures the current PC
//   Epc                 : PC at the last exception
//   RasEmpty            : return stack holds no entries
// A redirect seen while the request is not advancing is latched (PEND) and
// applied on the next advance unless a newer redirect arrives first.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(EXC_VEC_DEF),
  parameter int                RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              FetchReady,
  output logic              FetchValid,
  output logic [ADDR_W-3:0] PC,
  input  logic              BrTaken,
  input  logic [ADDR_W-3:0] BrTarget,
  input  logic              JmpValid,
  input  logic [ADDR_W-3:0] JmpTarget,
  input  logic              Call,
  input  logic              Ret,
  input  logic              Exc,
  output logic [ADDR_W-3:0] Epc,
  output logic              RasEmpty
);

  localparam int          PW       = ADDR_W - 2;
  localparam logic [PW-1:0] RESET_PC = RESET_VEC[ADDR_W-1:2];
  localparam logic [PW-1:0] EXC_PC   = EXC_VEC[ADDR_W-1:2];

  pc_state_t     state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [PW-1:0] pend_tgt_q, pend_tgt_d;
  logic [PW-1:0] epc_q, epc_d;
  logic          fv_q, fv_d;

  logic [PW-1:0] ras_top;
  logic          ras_empty;
  logic          ras_push, ras_pop;

  logic          ret_ok, rdq, adv;
  redir_src_t    src;
  logic [PW-1:0] tgt;
  logic [PW-1:0] pc_inc;

  // A return with nothing on the stack is not a redirect at all, so lower
  // priority sources still get to compete.
  assign ret_ok = Ret & ~ras_empty;
  assign src    = redir_pick(Exc, ret_ok, JmpValid, BrTaken);
  assign rdq    = (src != SRC_NONE);
  assign adv    = fv_q & FetchReady & ~Stall;
  assign pc_inc = pc_q + PW'(1);

  // Stack side effects follow the winner only, applied or latched alike.
  assign ras_pop  = (src == SRC_RET);
  assign ras_push = (src == SRC_JMP) & Call;

  always_comb begin
    case (src)
      SRC_EXC: tgt = EXC_PC;
      SRC_RET: tgt = ras_top;
      SRC_JMP: tgt = JmpTarget;
      default: tgt = BrTarget;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    epc_d      = epc_q;
    fv_d       = 1'b1;            // request is up from the cycle after BOOT

    if (src == SRC_EXC) epc_d = pc_q;

    if (adv) begin
      // A fresh redirect beats (and discards) a latched one.
      if (rdq)                    pc_d = tgt;
      else if (state_q == ST_PEND) pc_d = pend_tgt_q;
      else                        pc_d = pc_inc;
      state_d = ST_RUN;
    end else if (rdq) begin
      // Newest redirect wins the pending slot; PC holds for the handshake.
      pend_tgt_d = tgt;
      state_d    = ST_PEND;
    end else if (state_q == ST_BOOT) begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pend_tgt_q <= '0;
      epc_q      <= '0;
      fv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      epc_q      <= epc_d;
      fv_q       <= fv_d;
    end
  end

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (PW)
  ) u_ras (
    .clk       (Clk),
    .rst       (Reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  assign FetchValid = fv_q;
  assign PC         = pc_q;
  assign Epc        = epc_q;
  assign RasEmpty   = ras_empty;

endmodule
